// File: rtl/draw_fill_ctrl.sv
// draw_fill_ctrl -- rectangle fill engine with an AXI4 write master.
//
// Fills a WBLK x HGT rectangle (WBLK counted in 8-pixel bursts, HGT in
// lines) with a single 32-bit COLOR. Each burst is eight 32-bit beats
// (AWLEN=7) at a 32-byte aligned address. Exactly one burst is in flight
// at a time: AW handshake, then eight W beats, then the B response, before
// the next AW is issued.
//
// Handshake rule used on every channel: a transfer happens on a rising
// ACLK edge where VALID and READY are both 1; VALID is decoded from state
// only, never from READY, and the payload holds while VALID is high and
// READY is low.
//
// Ports:
//   ACLK, ARESETN        clock, synchronous active-low reset
//   START                one-cycle fill request (accepted only when idle)
//   BASE, STRIDE         top-left byte address / line pitch (bits [4:0] ignored)
//   WBLK, HGT            width in bursts / height in lines
//   COLOR                fill pixel value
//   BUSY, DONE, ERR      status: fill active, completion pulse, sticky BRESP error
//   M_AXI_AW*/W*/B*      AXI4 write channels (no read channels)
module draw_fill_ctrl #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            START,
    input  logic [31:0]                     BASE,
    input  logic [15:0]                     STRIDE,
    input  logic [7:0]                      WBLK,
    input  logic [9:0]                      HGT,
    input  logic [31:0]                     COLOR,
    output logic                            BUSY,
    output logic                            DONE,
    output logic                            ERR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic [3:0]                      M_AXI_AWCACHE,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] line_q, line_d;     // 32-byte aligned start of current line
    logic [31:0] addr_q, addr_d;     // address of the current burst
    logic [15:0] stride_q, stride_d;
    logic [7:0]  wblk_q, wblk_d;
    logic [9:0]  hgt_q, hgt_d;
    logic [31:0] color_q, color_d;
    logic [7:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [2:0]  beat_q, beat_d;
    logic        err_q, err_d;
    logic        done_q, done_d;

    logic [31:0] next_line;

    // Stride with its low five bits dropped, so line addresses stay aligned.
    assign next_line = line_q + {16'h0000, stride_q[15:5], 5'b00000};

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        wblk_d   = wblk_q;
        hgt_d    = hgt_q;
        color_d  = color_q;
        x_d      = x_q;
        y_d      = y_q;
        beat_d   = beat_q;
        err_d    = err_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    stride_d = STRIDE;
                    wblk_d   = WBLK;
                    hgt_d    = HGT;
                    color_d  = COLOR;
                    line_d   = {BASE[31:5], 5'b00000};
                    addr_d   = {BASE[31:5], 5'b00000};
                    x_d      = 8'd0;
                    y_d      = 10'd0;
                    beat_d   = 3'd0;
                    err_d    = 1'b0;
                    state_d  = (WBLK != 8'd0 && HGT != 10'd0) ? S_AW : S_FIN;
                end
            end
            S_AW: begin
                beat_d = 3'd0;
                if (M_AXI_AWREADY) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                if (M_AXI_WREADY) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (x_q != wblk_q - 8'd1) begin
                        x_d     = x_q + 8'd1;
                        addr_d  = addr_q + 32'd32;
                        state_d = S_AW;
                    end else begin
                        x_d = 8'd0;
                        y_d = y_q + 10'd1;
                        if (y_q == hgt_q - 10'd1) begin
                            state_d = S_FIN;
                        end else begin
                            line_d  = next_line;
                            addr_d  = next_line;
                            state_d = S_AW;
                        end
                    end
                end
            end
            S_FIN: begin
                // DONE is registered, so the pulse lands in the IDLE cycle
                // that follows, where BUSY is already low.
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q  <= S_IDLE;
            line_q   <= 32'd0;
            addr_q   <= 32'd0;
            stride_q <= 16'd0;
            wblk_q   <= 8'd0;
            hgt_q    <= 10'd0;
            color_q  <= 32'd0;
            x_q      <= 8'd0;
            y_q      <= 10'd0;
            beat_q   <= 3'd0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            wblk_q   <= wblk_d;
            hgt_q    <= hgt_d;
            color_q  <= color_d;
            x_q      <= x_d;
            y_q      <= y_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign BUSY          = (state_q != S_IDLE);
    assign DONE          = done_q;
    assign ERR           = err_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = 8'd7;
    assign M_AXI_AWSIZE  = 3'd2;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWVALID = (state_q == S_AW);
    assign M_AXI_WDATA   = color_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WLAST   = (state_q == S_W) && (beat_q == 3'd7);
    assign M_AXI_WVALID  = (state_q == S_W);
    assign M_AXI_BREADY  = (state_q == S_B);

endmodule
